// File: rtl/switch_poller_pkg.sv
// Shared types and default parameters for the switch poller.
// Holds the poll FSM state encoding and the parameter defaults.
package switch_poller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_EVAL    = 2'd3
    } poll_state_t;

    localparam int DEF_WIDTH        = 4;
    localparam int DEF_POLL_DIV     = 50000;
    localparam int DEF_DEBOUNCE_CNT = 4;

    // Width of the debounce counter; it saturates at DEBOUNCE_CNT (at most 255).
    localparam int STABLE_CNT_W = 8;

endpackage

// File: rtl/switch_poller_if.sv
// Switch-PIO read port plus the change-event stream of the switch poller.
// The master side is the poller. The slave side is the PIO together with the event consumer.
interface switch_poller_if #(
    parameter int WIDTH = switch_poller_pkg::DEF_WIDTH
);
    logic [1:0]       pio_address;
    logic             pio_read;
    logic [31:0]      pio_readdata;
    logic [WIDTH-1:0] sw_state;
    logic             evt_valid;
    logic             evt_ready;
    logic [WIDTH-1:0] evt_data;
    logic [WIDTH-1:0] evt_changed;
    logic             evt_overflow;
    logic             irq;

    modport master (
        output pio_address,
        output pio_read,
        input  pio_readdata,
        output sw_state,
        output evt_valid,
        input  evt_ready,
        output evt_data,
        output evt_changed,
        output evt_overflow,
        output irq
    );

    modport slave (
        input  pio_address,
        input  pio_read,
        output pio_readdata,
        input  sw_state,
        output evt_ready,
        input  evt_valid,
        input  evt_data,
        input  evt_changed,
        input  evt_overflow,
        input  irq
    );

endinterface

// File: rtl/switch_debounce.sv
// Debounce of polled switch samples: accepts a value after DEBOUNCE_CNT equal samples in a row.
// sw_state updates on the sample_valid edge, and the change flag and mask are combinational during sample_valid. There is no backpressure.
module switch_debounce
    import switch_poller_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    output logic [WIDTH-1:0] sw_state,
    output logic             chg_vld,
    output logic [WIDTH-1:0] chg_mask,
    output logic [WIDTH-1:0] new_state
);

    localparam logic [STABLE_CNT_W-1:0] CNT_MAX = STABLE_CNT_W'(DEBOUNCE_CNT);

    logic [WIDTH-1:0]        candidate;
    logic [STABLE_CNT_W-1:0] stable_cnt;
    logic [WIDTH-1:0]        sw_state_q;

    logic                    match;
    logic [WIDTH-1:0]        candidate_nxt;
    logic [STABLE_CNT_W-1:0] stable_cnt_nxt;

    always_comb begin
        match          = (sample == candidate);
        candidate_nxt  = candidate;
        stable_cnt_nxt = stable_cnt;
        if (match) begin
            if (stable_cnt != CNT_MAX) begin
                stable_cnt_nxt = stable_cnt + STABLE_CNT_W'(1);
            end
        end else begin
            candidate_nxt  = sample;
            stable_cnt_nxt = STABLE_CNT_W'(1);
        end
    end

    // A change is reported only on the poll where the candidate reaches stability
    // and differs from the accepted value. Saturation keeps the report from repeating.
    always_comb begin
        chg_vld   = sample_valid && (stable_cnt_nxt == CNT_MAX) && (candidate_nxt != sw_state_q);
        chg_mask  = candidate_nxt ^ sw_state_q;
        new_state = candidate_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            candidate  <= '0;
            stable_cnt <= '0;
            sw_state_q <= '0;
        end else if (sample_valid) begin
            candidate  <= candidate_nxt;
            stable_cnt <= stable_cnt_nxt;
            if (chg_vld) begin
                sw_state_q <= candidate_nxt;
            end
        end
    end

    assign sw_state = sw_state_q;

endmodule

// File: rtl/switch_poller.sv
// Polls a switch PIO every POLL_DIV clocks, debounces it and posts change events on a valid/ready stream.
// Outputs update 3 cycles after pio_read. An unaccepted event absorbs later changes (overflow flag) and never stalls polling.
module switch_poller
    import switch_poller_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int POLL_DIV     = DEF_POLL_DIV,
    parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    switch_poller_if.master bus
);

    localparam int               CNT_W     = $clog2(POLL_DIV);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(POLL_DIV - 1);

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    poll_state_t      state;
    poll_state_t      state_nxt;
    logic             pio_read_q;
    logic             capture_en;
    logic             sample_valid;
    logic [WIDTH-1:0] sample;

    logic [WIDTH-1:0] sw_state;
    logic             chg_vld;
    logic [WIDTH-1:0] chg_mask;
    logic [WIDTH-1:0] new_state;

    logic             evt_valid_q;
    logic [WIDTH-1:0] evt_data_q;
    logic [WIDTH-1:0] evt_changed_q;
    logic             evt_overflow_q;
    logic             xfer;

    logic             unused_readdata_hi;

    // Tick counter. It is held at zero while disabled, so that a re-enable always waits a full period.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    assign tick = enable && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        capture_en   = 1'b0;
        sample_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tick) begin
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                capture_en = 1'b1;
                state_nxt  = ST_EVAL;
            end
            ST_EVAL: begin
                sample_valid = 1'b1;
                state_nxt    = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // The strobe comes from its own flop and is aligned with the READ state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pio_read_q <= 1'b0;
        end else begin
            pio_read_q <= (state_nxt == ST_READ);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample <= '0;
        end else if (capture_en) begin
            sample <= bus.pio_readdata[WIDTH-1:0];
        end
    end

    assign unused_readdata_hi = ^bus.pio_readdata[31:WIDTH];

    switch_debounce #(
        .WIDTH        (WIDTH),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_debounce (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .sw_state     (sw_state),
        .chg_vld      (chg_vld),
        .chg_mask     (chg_mask),
        .new_state    (new_state)
    );

    assign xfer = evt_valid_q && bus.evt_ready;

    // A change that coincides with a transfer starts a fresh event. Otherwise it merges into the pending one.
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_valid_q    <= 1'b0;
            evt_data_q     <= '0;
            evt_changed_q  <= '0;
            evt_overflow_q <= 1'b0;
        end else if (chg_vld) begin
            evt_valid_q <= 1'b1;
            evt_data_q  <= new_state;
            if (!evt_valid_q || xfer) begin
                evt_changed_q  <= chg_mask;
                evt_overflow_q <= 1'b0;
            end else begin
                evt_changed_q  <= evt_changed_q | chg_mask;
                evt_overflow_q <= 1'b1;
            end
        end else if (xfer) begin
            evt_valid_q    <= 1'b0;
            evt_changed_q  <= '0;
            evt_overflow_q <= 1'b0;
        end
    end

    assign bus.pio_address  = 2'b00;
    assign bus.pio_read     = pio_read_q;
    assign bus.sw_state     = sw_state;
    assign bus.evt_valid    = evt_valid_q;
    assign bus.evt_data     = evt_data_q;
    assign bus.evt_changed  = evt_changed_q;
    assign bus.evt_overflow = evt_overflow_q;
    assign bus.irq          = evt_valid_q;

endmodule

// File: tb/tb_switch_poller.sv
// Randomized and directed bench for switch_poller against a reference model kept in the bench.
module tb_switch_poller;

    localparam int WIDTH    = 4;
    localparam int POLL_DIV = 8;
    localparam int DEB      = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [WIDTH-1:0] sw_in;

    int n_cmp   = 0;
    int n_bad   = 0;
    int n_reads = 0;

    // Reference model state
    logic [WIDTH-1:0] m_sw;
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] m_changed;
    logic             m_valid;
    logic             m_ovf;
    logic             m_read;
    int               m_period;
    int               m_stage;
    logic [WIDTH-1:0] m_samp;
    logic [WIDTH-1:0] hist[$];

    switch_poller_if #(.WIDTH(WIDTH)) bus ();

    switch_poller #(
        .WIDTH        (WIDTH),
        .POLL_DIV     (POLL_DIV),
        .DEBOUNCE_CNT (DEB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advances the model across the coming rising edge. It uses this cycle's inputs and the observed read strobe.
    task automatic model_step(input logic rd);
        logic             xfer;
        logic             evt;
        logic             same;
        logic [WIDTH-1:0] mask;
        if (reset) begin
            m_sw = '0; m_data = '0; m_changed = '0; m_valid = 1'b0; m_ovf = 1'b0;
            m_read = 1'b0; m_period = 0; m_stage = 0;
            hist.delete();
        end else begin
            xfer = m_valid && bus.evt_ready;
            evt  = 1'b0;
            mask = '0;
            if (m_stage == 1) begin
                hist.push_back(m_samp);
                if (hist.size() > DEB) void'(hist.pop_front());
                if (hist.size() == DEB) begin
                    same = 1'b1;
                    foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
                    if (same && hist[0] != m_sw) begin
                        evt  = 1'b1;
                        mask = hist[0] ^ m_sw;
                        m_sw = hist[0];
                    end
                end
            end
            if (m_stage > 0) m_stage--;
            if (rd) begin
                m_samp  = sw_in;
                m_stage = 2;
            end
            // A poll starts one period after the counter began counting enabled cycles.
            m_read   = enable && (m_period == POLL_DIV - 1);
            m_period = !enable ? 0 : (m_period == POLL_DIV - 1) ? 0 : m_period + 1;
            if (evt) begin
                m_data = m_sw;
                if (!m_valid || xfer) begin
                    m_changed = mask;
                    m_ovf     = 1'b0;
                end else begin
                    m_changed = m_changed | mask;
                    m_ovf     = 1'b1;
                end
                m_valid = 1'b1;
            end else if (xfer) begin
                m_valid   = 1'b0;
                m_changed = '0;
                m_ovf     = 1'b0;
            end
        end
    endtask

    task automatic run_cycle();
        logic        rd;
        logic [31:0] rdata;
        rd = bus.pio_read;
        if (rd) n_reads++;
        model_step(rd);
        @(posedge clk);
        #1;
        if (rd) begin
            rdata = $urandom;
            rdata[WIDTH-1:0] = sw_in;
            bus.pio_readdata = rdata;
        end
        @(negedge clk);
        check_eq("pio_read", bus.pio_read, m_read);
        check_eq("pio_address", bus.pio_address, 0);
        check_eq("sw_state", bus.sw_state, m_sw);
        check_eq("evt_valid", bus.evt_valid, m_valid);
        check_eq("evt_data", bus.evt_data, m_data);
        check_eq("evt_changed", bus.evt_changed, m_changed);
        check_eq("evt_overflow", bus.evt_overflow, m_ovf);
        check_eq("irq", bus.irq, m_valid);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) run_cycle();
        reset = 1'b0;
    endtask

    // One complete poll that returns val. The consumer's ready is driven to rdy only in the evaluate cycle.
    task automatic poll_with(input logic [WIDTH-1:0] val, input logic rdy);
        sw_in = val;
        for (int i = 0; i < 4 * POLL_DIV && !bus.pio_read; i++) run_cycle();
        check_eq("poll_started", bus.pio_read, 1);
        run_cycle();
        run_cycle();
        bus.evt_ready = rdy;
        run_cycle();
        bus.evt_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int r0;
        reset            = 1'b1;
        enable           = 1'b1;
        sw_in            = 4'b0101;
        bus.evt_ready    = 1'b0;
        bus.pio_readdata = '0;

        // Reset held with switches at 0101. The read strobe must stay low throughout.
        do_reset(6);
        check_eq("reset_evt_valid", bus.evt_valid, 0);

        // The held value is accepted on the third poll.
        r0 = n_reads;
        for (int i = 0; i < 6 * POLL_DIV && !bus.evt_valid; i++) run_cycle();
        check_eq("s1_evt_seen", bus.evt_valid, 1);
        check_eq("s1_polls", n_reads - r0, 3);
        check_eq("s1_evt_data", bus.evt_data, 4'b0101);
        check_eq("s1_evt_changed", bus.evt_changed, 4'b0101);
        check_eq("s1_irq", bus.irq, 1);

        // A glitching input only counts once it has been stable for the full run.
        do_reset(2);
        poll_with(4'b0101, 1'b0);
        poll_with(4'b0000, 1'b0);
        poll_with(4'b0101, 1'b0);
        poll_with(4'b0101, 1'b0);
        check_eq("s2_no_evt_yet", bus.evt_valid, 0);
        check_eq("s2_sw_hold", bus.sw_state, 4'b0000);
        poll_with(4'b0101, 1'b0);
        check_eq("s2_evt", bus.evt_valid, 1);
        check_eq("s2_sw_new", bus.sw_state, 4'b0101);

        // Two changes with no consumer are merged into one event.
        do_reset(2);
        repeat (3) poll_with(4'b0001, 1'b0);
        check_eq("s3_first_data", bus.evt_data, 4'b0001);
        check_eq("s3_first_ovf", bus.evt_overflow, 0);
        repeat (3) poll_with(4'b0011, 1'b0);
        check_eq("s3_merge_data", bus.evt_data, 4'b0011);
        check_eq("s3_merge_changed", bus.evt_changed, 4'b0011);
        check_eq("s3_merge_ovf", bus.evt_overflow, 1);

        // A transfer that coincides with a new change starts a fresh event.
        repeat (2) poll_with(4'b0111, 1'b0);
        poll_with(4'b0111, 1'b1);
        check_eq("s4_valid", bus.evt_valid, 1);
        check_eq("s4_data", bus.evt_data, 4'b0111);
        check_eq("s4_changed", bus.evt_changed, 4'b0100);
        check_eq("s4_ovf", bus.evt_overflow, 0);
        bus.evt_ready = 1'b1;
        run_cycle();
        bus.evt_ready = 1'b0;
        check_eq("s4_drained", bus.evt_valid, 0);
        check_eq("s4_data_hold", bus.evt_data, 4'b0111);

        // Reset in the capture cycle aborts the poll. The next poll starts 8 edges after release.
        for (int i = 0; i < 4 * POLL_DIV && !bus.pio_read; i++) run_cycle();
        run_cycle();
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        check_eq("s5_sw_cleared", bus.sw_state, 0);
        check_eq("s5_read_low", bus.pio_read, 0);
        k = 0;
        while (k < 4 * POLL_DIV && !bus.pio_read) begin
            run_cycle();
            k++;
        end
        check_eq("s5_restart_edges", k, POLL_DIV);

        // While disabled no polls occur. After re-enable, the strobe appears in the 9th enabled cycle.
        enable = 1'b0;
        run_cycle();
        r0 = n_reads;
        repeat (39) run_cycle();
        check_eq("s6_disabled_reads", n_reads - r0, 0);
        enable = 1'b1;
        k = 1;
        while (k < 4 * POLL_DIV && !bus.pio_read) begin
            run_cycle();
            k++;
        end
        check_eq("s6_reenable_cycle", k, POLL_DIV + 1);

        // Random traffic: slowly changing switches, a random consumer, occasional disable and reset.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) sw_in = 4'($urandom);
            bus.evt_ready = ($urandom_range(0, 3) == 0);
            enable        = ($urandom_range(0, 49) != 0);
            reset         = ($urandom_range(0, 399) == 0);
            run_cycle();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/switch_poller.md
SWITCH_POLLER -- requirements
Module: switch_poller

Interface
REQ-001 Parameter WIDTH, default 4: number of switch bits taken from readdata[WIDTH-1:0].
REQ-002 Parameter POLL_DIV, default 50000: clocks between poll starts; legal range is 4 or more.
REQ-003 Parameter DEBOUNCE_CNT, default 4: consecutive equal samples required to accept a value; legal range is 1 to 255.
REQ-004 clk  in  1: single clock; all logic on its rising edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 enable  in  1: polling enable.
REQ-007 pio_address  out  2: switch PIO address; always 0.
REQ-008 pio_read  out  1: registered read strobe to the PIO, one cycle wide.
REQ-009 pio_readdata  in  32: PIO read data; registered by the PIO, valid one cycle after the address.
REQ-010 sw_state  out  WIDTH: current debounced switch value.
REQ-011 evt_valid  out  1: change event pending.
REQ-012 evt_ready  in  1: consumer accept; a transfer occurs when evt_valid and evt_ready are both high.
REQ-013 evt_data  out  WIDTH: debounced value carried by the event.
REQ-014 evt_changed  out  WIDTH: mask of bits that changed since the last accepted event.
REQ-015 evt_overflow  out  1: at least one event was merged into the pending event.
REQ-016 irq  out  1: equals evt_valid.

Function
REQ-017 The tick counter SHALL count 0..POLL_DIV-1 while enable=1, wrap to 0, and assert tick when at POLL_DIV-1; it SHALL be held at 0 while enable=0.
REQ-018 The FSM SHALL have four states:
- IDLE: go to READ on tick.
- READ: pio_read=1; go to CAPTURE.
- CAPTURE: register pio_readdata[WIDTH-1:0] as the sample; go to EVAL.
- EVAL: perform the debounce update and event generation; go to IDLE.
REQ-019 If enable is deasserted mid-poll, the FSM SHALL complete the poll and then remain in IDLE.
REQ-020 With pio_read high in cycle R, updated sw_state and event outputs SHALL be visible in cycle R+3.
REQ-021 Debounce update in EVAL:
- If sample equals candidate, stable_cnt SHALL increment, saturating at DEBOUNCE_CNT.
- Otherwise candidate SHALL be loaded with sample and stable_cnt set to 1.
REQ-022 When the updated stable_cnt equals DEBOUNCE_CNT and candidate differs from sw_state, sw_state SHALL load candidate and an event SHALL be generated; otherwise no event is generated.
REQ-023 An event with no event pending SHALL load:
- evt_valid=1;
- evt_data=new sw_state;
- evt_changed=new XOR old sw_state;
- evt_overflow=0.
REQ-024 An event while an event is pending and not transferring SHALL:
- replace evt_data;
- OR the new change mask into evt_changed;
- set evt_overflow=1.
REQ-025 An event in the same cycle as a transfer SHALL load as a fresh event: evt_changed=new mask only, evt_overflow=0, evt_valid stays 1.
REQ-026 A transfer with no new event SHALL clear evt_valid, evt_changed and evt_overflow; evt_data holds its value.
REQ-027 evt_valid SHALL NOT depend combinationally on evt_ready.

Reset
REQ-028 While reset=1, the block SHALL set:
- FSM to IDLE, tick counter 0;
- pio_read 0, pio_address 0;
- sample, candidate, stable_cnt and sw_state 0;
- evt_valid, evt_data, evt_changed, evt_overflow and irq 0.
REQ-029 A reset asserted mid-poll SHALL abort the poll; pio_read SHALL be 0 in the cycle after the reset edge.

Structure
REQ-030 Package switch_poller_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-031 The debounce logic (candidate, stable_cnt, sw_state, change detection) SHALL be a sub-module named switch_debounce, driven by a sample_valid strobe that is high in EVAL.

Verification (POLL_DIV=8, DEBOUNCE_CNT=3, WIDTH=4)
REQ-032 Bench SHALL cover:
- Release reset with input 0101 held -> one event on the 3rd poll: evt_data=0101, evt_changed=0101, irq=1; no pio_read while reset=1.
- Polls return 0101, 0000, 0101, 0101, 0101 -> exactly one event, after the last poll; sw_state 0000 until then.
- evt_ready=0; state goes 0000->0001, then later 0001->0011 -> evt_data=0011, evt_changed=0011, evt_overflow=1.
- evt_ready=1 in the cycle a new event (0011->0111) is generated -> evt_valid stays 1, evt_changed=0100, evt_overflow=0.
- Reset asserted in the CAPTURE cycle -> next cycle all outputs 0 and FSM in IDLE; the following poll starts 8 cycles after reset release.
- enable=0 for 40 cycles -> no pio_read; re-enable -> first pio_read 9 cycles later (tick at count 7, then READ).
